// File: rtl/l2_cache_pkg.sv
// Shared definitions for the N-way write-back/write-through L2 cache:
// controller state encoding and address field width helpers.
package l2_cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_WRITEBACK = 3'd2,
    ST_FILL      = 3'd3,
    ST_WT_WRITE  = 3'd4,
    ST_RESP      = 3'd5
  } l2_state_e;

  function automatic int offset_bits(input int block_size);
    return $clog2(block_size);
  endfunction

  function automatic int index_bits(input int cache_blocks, input int num_ways);
    return $clog2(cache_blocks / num_ways);
  endfunction

  function automatic int way_bits(input int num_ways);
    return $clog2(num_ways);
  endfunction

  function automatic int tag_bits(input int addr_width, input int block_size,
                                  input int cache_blocks, input int num_ways);
    return addr_width - offset_bits(block_size) - index_bits(cache_blocks, num_ways);
  endfunction

endpackage

// File: rtl/l2_lru_ctrl.sv
// True-LRU age tracking per set. Age 0 is most recent; the victim is the
// lowest-index invalid way, otherwise the way holding the maximum age.
module l2_lru_ctrl
  import l2_cache_pkg::*;
#(
  parameter int NUM_SETS = 4,
  parameter int NUM_WAYS = 2,
  localparam int IDX_W = $clog2(NUM_SETS),
  localparam int WAY_W = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_W-1:0]    sel_set,
  input  logic [NUM_WAYS-1:0] set_valid,
  output logic [WAY_W-1:0]    victim_way,
  input  logic                upd_en,
  input  logic [WAY_W-1:0]    upd_way
);

  logic [WAY_W-1:0] age_q [NUM_SETS][NUM_WAYS];
  logic             found;

  always_comb begin
    found      = 1'b0;
    victim_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found && !set_valid[w]) begin
        found      = 1'b1;
        victim_way = WAY_W'(w);
      end
    end
    if (!found) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (age_q[sel_set][w] == WAY_W'(NUM_WAYS - 1)) victim_way = WAY_W'(w);
      end
    end
  end

  // Ways younger than the accessed one age by one; the accessed way becomes 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          age_q[s][w] <= WAY_W'(w);
    end else if (upd_en) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (WAY_W'(w) == upd_way)
          age_q[sel_set][w] <= '0;
        else if (age_q[sel_set][w] < age_q[sel_set][upd_way])
          age_q[sel_set][w] <= age_q[sel_set][w] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_cache_wb.sv
// N-way set-associative L2 with true-LRU replacement and a compile-time
// write-back/write-allocate or write-through/no-allocate policy.
module l2_cache_wb
  import l2_cache_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int BLOCK_SIZE   = 4,
  parameter int CACHE_BLOCKS = 8,
  parameter int NUM_WAYS     = 2,
  parameter int WRITE_BACK   = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [ADDR_WIDTH-1:0]                 l1_cache_addr,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l1_cache_data_in,
  input  logic                                  l1_cache_read,
  input  logic                                  l1_cache_write,
  output logic                                  l1_cache_ready,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l1_block_data_out,
  output logic                                  l1_block_valid,
  output logic                                  l1_cache_hit,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_block,
  input  logic                                  mem_ready,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_out,
  output logic                                  mem_read,
  output logic                                  mem_write,
  output logic [2:0]                            dbg_state
);

  localparam int NUM_SETS = CACHE_BLOCKS / NUM_WAYS;
  localparam int OFF_W    = offset_bits(BLOCK_SIZE);
  localparam int IDX_W    = index_bits(CACHE_BLOCKS, NUM_WAYS);
  localparam int TAG_W    = tag_bits(ADDR_WIDTH, BLOCK_SIZE, CACHE_BLOCKS, NUM_WAYS);
  localparam int WAY_W    = way_bits(NUM_WAYS);
  localparam int BLK_W    = BLOCK_SIZE * DATA_WIDTH;

  // Handshake: L1 request is taken on a rising edge with l1_cache_ready=1;
  // memory strobes stay high with stable address/data until the edge that
  // samples mem_ready=1, and drop on that same edge.
  l2_state_e state, state_n;

  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    req_set;
  logic [BLK_W-1:0]    req_data;
  logic                req_wr;
  logic [WAY_W-1:0]    vic_way_q;
  logic                hit_q;
  logic [OFF_W-1:0]    unused_offset;

  logic [TAG_W-1:0]    tag_mem  [NUM_SETS][NUM_WAYS];
  logic [BLK_W-1:0]    data_mem [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q  [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q  [NUM_SETS];

  logic                hit;
  logic [WAY_W-1:0]    hit_way;
  logic [WAY_W-1:0]    vic_way;
  logic                line_we, line_dirty, lru_upd;
  logic [WAY_W-1:0]    line_way;
  logic [BLK_W-1:0]    line_wdata;
  logic                resp_load, resp_hit;
  logic [BLK_W-1:0]    resp_data;
  logic                mem_go, mem_go_wr, mem_clr;
  logic [ADDR_WIDTH-1:0] mem_addr_n;
  logic [BLK_W-1:0]    mem_data_n;

  assign unused_offset  = l1_cache_addr[OFF_W-1:0];
  assign l1_cache_ready = (state == ST_IDLE);
  assign dbg_state      = state;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit && valid_q[req_set][w] && tag_mem[req_set][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  l2_lru_ctrl #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS)) u_lru (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel_set   (req_set),
    .set_valid (valid_q[req_set]),
    .victim_way(vic_way),
    .upd_en    (lru_upd),
    .upd_way   (line_way)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    line_we    = 1'b0;
    line_dirty = 1'b0;
    line_way   = hit_way;
    line_wdata = req_data;
    lru_upd    = 1'b0;
    resp_load  = 1'b0;
    resp_hit   = 1'b0;
    resp_data  = req_data;
    mem_go     = 1'b0;
    mem_go_wr  = 1'b0;
    mem_clr    = 1'b0;
    mem_addr_n = {req_tag, req_set, {OFF_W{1'b0}}};
    mem_data_n = req_data;
    case (state)
      ST_IDLE: if (l1_cache_read || l1_cache_write) state_n = ST_LOOKUP;
      ST_LOOKUP: begin
        if (hit) begin
          lru_upd  = 1'b1;
          resp_hit = 1'b1;
          if (req_wr) begin
            line_we    = 1'b1;
            line_dirty = (WRITE_BACK != 0);
          end else begin
            resp_data = data_mem[req_set][hit_way];
          end
          if (req_wr && WRITE_BACK == 0) begin
            state_n   = ST_WT_WRITE;
            mem_go    = 1'b1;
            mem_go_wr = 1'b1;
          end else begin
            state_n   = ST_RESP;
            resp_load = 1'b1;
          end
        end else if (WRITE_BACK != 0) begin
          line_way = vic_way;
          if (valid_q[req_set][vic_way] && dirty_q[req_set][vic_way]) begin
            state_n    = ST_WRITEBACK;
            mem_go     = 1'b1;
            mem_go_wr  = 1'b1;
            mem_addr_n = {tag_mem[req_set][vic_way], req_set, {OFF_W{1'b0}}};
            mem_data_n = data_mem[req_set][vic_way];
          end else if (!req_wr) begin
            state_n = ST_FILL;
            mem_go  = 1'b1;
          end else begin
            line_we    = 1'b1;
            line_dirty = 1'b1;
            lru_upd    = 1'b1;
            resp_load  = 1'b1;
            state_n    = ST_RESP;
          end
        end else begin
          state_n   = req_wr ? ST_WT_WRITE : ST_FILL;
          mem_go    = 1'b1;
          mem_go_wr = req_wr;
        end
      end
      ST_WRITEBACK: begin
        line_way = vic_way_q;
        if (mem_ready) begin
          mem_clr = 1'b1;
          if (!req_wr) begin
            state_n = ST_FILL;
            mem_go  = 1'b1;
          end else begin
            line_we    = 1'b1;
            line_dirty = 1'b1;
            lru_upd    = 1'b1;
            resp_load  = 1'b1;
            state_n    = ST_RESP;
          end
        end
      end
      ST_FILL: begin
        line_way = vic_way_q;
        if (mem_ready) begin
          mem_clr    = 1'b1;
          line_we    = 1'b1;
          line_wdata = mem_data_block;
          lru_upd    = 1'b1;
          resp_load  = 1'b1;
          resp_data  = mem_data_block;
          state_n    = ST_RESP;
        end
      end
      ST_WT_WRITE: begin
        if (mem_ready) begin
          mem_clr   = 1'b1;
          resp_load = 1'b1;
          resp_hit  = hit_q;
          state_n   = ST_RESP;
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_tag   <= '0;
      req_set   <= '0;
      req_data  <= '0;
      req_wr    <= 1'b0;
      vic_way_q <= '0;
      hit_q     <= 1'b0;
    end else begin
      if (state == ST_IDLE && (l1_cache_read || l1_cache_write)) begin
        req_tag  <= l1_cache_addr[ADDR_WIDTH-1 -: TAG_W];
        req_set  <= l1_cache_addr[OFF_W +: IDX_W];
        req_data <= l1_cache_data_in;
        req_wr   <= l1_cache_write;
      end
      if (state == ST_LOOKUP) begin
        vic_way_q <= vic_way;
        hit_q     <= hit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[req_set][line_way]  <= req_tag;
      data_mem[req_set][line_way] <= line_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else if (line_we) begin
      valid_q[req_set][line_way] <= 1'b1;
      dirty_q[req_set][line_way] <= line_dirty;
    end
  end

  // A fill/write-back completion clears the strobe; a follow-on phase set on
  // the same edge takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l1_block_valid    <= 1'b0;
      l1_cache_hit      <= 1'b0;
      l1_block_data_out <= '0;
      mem_read          <= 1'b0;
      mem_write         <= 1'b0;
      mem_addr          <= '0;
      mem_data_out      <= '0;
    end else begin
      l1_block_valid <= resp_load;
      if (resp_load) begin
        l1_block_data_out <= resp_data;
        l1_cache_hit      <= resp_hit;
      end else if (state == ST_RESP) begin
        l1_cache_hit <= 1'b0;
      end
      if (mem_clr) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
      end
      if (mem_go) begin
        mem_read     <= !mem_go_wr;
        mem_write    <= mem_go_wr;
        mem_addr     <= mem_addr_n;
        mem_data_out <= mem_data_n;
      end
    end
  end

endmodule

// File: tb/tb_l2_cache_wb.sv
// Directed bench: one write-back instance (index 0) and one write-through
// instance (index 1) driven by a small memory responder task.
module tb_l2_cache_wb;

  logic        clk;
  logic        rst_n;
  logic [7:0]  l1_addr   [2];
  logic [31:0] l1_din    [2];
  logic        l1_rd     [2];
  logic        l1_wr     [2];
  logic        l1_ready  [2];
  logic [31:0] l1_dout   [2];
  logic        l1_valid  [2];
  logic        l1_hit    [2];
  logic [31:0] mem_blk   [2];
  logic        mem_rdy   [2];
  logic [7:0]  m_addr    [2];
  logic [31:0] m_dout    [2];
  logic        m_rd      [2];
  logic        m_wr      [2];
  logic [2:0]  dbg_st    [2];

  int n_cmp = 0;
  int n_err = 0;

  // per-transaction capture
  logic [31:0] cap_data;
  logic        cap_hit;
  logic        got_valid;
  int          lat, n_rd, n_wr, rd_cyc;
  logic [7:0]  rd_addr, wr_addr;
  logic [31:0] wr_data;
  logic        unstable, early_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  l2_cache_wb #(.WRITE_BACK(1)) u_wb (
    .clk(clk), .rst_n(rst_n),
    .l1_cache_addr(l1_addr[0]), .l1_cache_data_in(l1_din[0]),
    .l1_cache_read(l1_rd[0]), .l1_cache_write(l1_wr[0]),
    .l1_cache_ready(l1_ready[0]), .l1_block_data_out(l1_dout[0]),
    .l1_block_valid(l1_valid[0]), .l1_cache_hit(l1_hit[0]),
    .mem_data_block(mem_blk[0]), .mem_ready(mem_rdy[0]),
    .mem_addr(m_addr[0]), .mem_data_out(m_dout[0]),
    .mem_read(m_rd[0]), .mem_write(m_wr[0]), .dbg_state(dbg_st[0])
  );

  l2_cache_wb #(.WRITE_BACK(0)) u_wt (
    .clk(clk), .rst_n(rst_n),
    .l1_cache_addr(l1_addr[1]), .l1_cache_data_in(l1_din[1]),
    .l1_cache_read(l1_rd[1]), .l1_cache_write(l1_wr[1]),
    .l1_cache_ready(l1_ready[1]), .l1_block_data_out(l1_dout[1]),
    .l1_block_valid(l1_valid[1]), .l1_cache_hit(l1_hit[1]),
    .mem_data_block(mem_blk[1]), .mem_ready(mem_rdy[1]),
    .mem_addr(m_addr[1]), .mem_data_out(m_dout[1]),
    .mem_read(m_rd[1]), .mem_write(m_wr[1]), .dbg_state(dbg_st[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one L1 request and act as memory until the response pulse.
  task automatic do_req(input int d, input logic rd, input logic wr, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic [31:0] mdata, input int delay);
    int       ph;
    logic     prev_rd, prev_wr;
    logic [7:0] ph_addr;
    ph = 0; prev_rd = 1'b0; prev_wr = 1'b0; ph_addr = '0;
    got_valid = 1'b0; lat = 0; n_rd = 0; n_wr = 0; rd_cyc = 0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; unstable = 1'b0; early_ready = 1'b0;
    cap_data = '0; cap_hit = 1'b0;
    @(negedge clk);
    l1_addr[d] = addr; l1_din[d] = wdata; l1_rd[d] = rd; l1_wr[d] = wr; mem_blk[d] = mdata;
    @(posedge clk);
    #1;
    l1_rd[d] = 1'b0; l1_wr[d] = 1'b0;
    for (int c = 0; c < 60 && !got_valid; c++) begin
      @(negedge clk);
      lat++;
      if (mem_rdy[d]) ph = 0;
      mem_rdy[d] = 1'b0;
      if (l1_ready[d]) early_ready = 1'b1;
      if (m_rd[d] && !prev_rd) begin n_rd++; rd_addr = m_addr[d]; end
      if (m_wr[d] && !prev_wr) begin n_wr++; wr_addr = m_addr[d]; wr_data = m_dout[d]; end
      if (m_rd[d]) rd_cyc++;
      if (m_rd[d] || m_wr[d]) begin
        if (ph == 0) ph_addr = m_addr[d];
        else if (m_addr[d] !== ph_addr) unstable = 1'b1;
        if (ph >= delay) mem_rdy[d] = 1'b1;
        ph++;
      end
      prev_rd = m_rd[d]; prev_wr = m_wr[d];
      if (l1_valid[d]) begin
        got_valid = 1'b1; cap_data = l1_dout[d]; cap_hit = l1_hit[d];
      end
    end
    mem_rdy[d] = 1'b0;
    if (!got_valid) check_eq("resp_timeout", 32'(got_valid), 32'd1);
  endtask

  initial begin
    logic seen;
    logic resp_after_rst;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      l1_addr[d] = '0; l1_din[d] = '0; l1_rd[d] = 1'b0; l1_wr[d] = 1'b0;
      mem_blk[d] = '0; mem_rdy[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_ready", 32'(l1_ready[d]), 32'd1);
      check_eq("rst_valid", 32'(l1_valid[d]), 32'd0);
      check_eq("rst_hit", 32'(l1_hit[d]), 32'd0);
      check_eq("rst_dout", l1_dout[d], 32'd0);
      check_eq("rst_mem_rw", {30'd0, m_rd[d], m_wr[d]}, 32'd0);
      check_eq("rst_mem_addr", 32'(m_addr[d]), 32'd0);
      check_eq("rst_mem_dout", m_dout[d], 32'd0);
      check_eq("rst_state", 32'(dbg_st[d]), 32'd0);
    end
    rst_n = 1'b1;

    // ---------------- write-back instance ----------------
    do_req(0, 1, 0, 8'h0A, 32'h0, 32'hFFFF_FFFF, 0);
    check_eq("wb_rd_miss_hit", 32'(cap_hit), 32'd0);
    check_eq("wb_rd_miss_data", cap_data, 32'hFFFF_FFFF);
    check_eq("wb_rd_miss_nrd", 32'(n_rd), 32'd1);
    check_eq("wb_rd_miss_addr", 32'(rd_addr), 32'h08);
    check_eq("wb_rd_miss_lat", 32'(lat), 32'd3);

    do_req(0, 1, 0, 8'h0A, 32'h0, 32'h0, 0);
    check_eq("wb_rd_hit_hit", 32'(cap_hit), 32'd1);
    check_eq("wb_rd_hit_data", cap_data, 32'hFFFF_FFFF);
    check_eq("wb_rd_hit_nrd", 32'(n_rd), 32'd0);
    check_eq("wb_rd_hit_lat", 32'(lat), 32'd2);
    @(negedge clk);
    check_eq("wb_pulse_end", 32'(l1_valid[0]), 32'd0);
    check_eq("wb_ready_back", 32'(l1_ready[0]), 32'd1);

    do_req(0, 0, 1, 8'h4A, 32'hBBBB_BBBB, 32'h0, 0);
    check_eq("wb_wr_miss_hit", 32'(cap_hit), 32'd0);
    check_eq("wb_wr_miss_mem", 32'(n_rd + n_wr), 32'd0);
    check_eq("wb_wr_miss_data", cap_data, 32'hBBBB_BBBB);
    check_eq("wb_wr_miss_lat", 32'(lat), 32'd2);

    do_req(0, 0, 1, 8'h4A, 32'hCCCC_CCCC, 32'h0, 0);
    check_eq("wb_wr_hit_hit", 32'(cap_hit), 32'd1);
    check_eq("wb_wr_hit_nwr", 32'(n_wr), 32'd0);

    do_req(0, 1, 0, 8'h0A, 32'h0, 32'h0, 0);
    check_eq("wb_touch_0a", 32'(cap_hit), 32'd1);

    do_req(0, 1, 0, 8'h8A, 32'h0, 32'h1234_5678, 0);
    check_eq("wb_evict_nwr", 32'(n_wr), 32'd1);
    check_eq("wb_evict_waddr", 32'(wr_addr), 32'h48);
    check_eq("wb_evict_wdata", wr_data, 32'hCCCC_CCCC);
    check_eq("wb_evict_nrd", 32'(n_rd), 32'd1);
    check_eq("wb_evict_raddr", 32'(rd_addr), 32'h88);
    check_eq("wb_evict_data", cap_data, 32'h1234_5678);
    check_eq("wb_evict_hit", 32'(cap_hit), 32'd0);
    check_eq("wb_evict_lat", 32'(lat), 32'd4);

    do_req(0, 1, 0, 8'h4A, 32'h0, 32'hA5A5_0000, 0);
    check_eq("wb_4a_miss_hit", 32'(cap_hit), 32'd0);
    check_eq("wb_4a_clean_nwr", 32'(n_wr), 32'd0);
    check_eq("wb_4a_raddr", 32'(rd_addr), 32'h48);
    check_eq("wb_4a_data", cap_data, 32'hA5A5_0000);

    do_req(0, 1, 0, 8'h0A, 32'h0, 32'h0F0F_0F0F, 5);
    check_eq("dly_hit", 32'(cap_hit), 32'd0);
    check_eq("dly_rd_cycles", 32'(rd_cyc), 32'd6);
    check_eq("dly_addr_stable", 32'(unstable), 32'd0);
    check_eq("dly_ready_low", 32'(early_ready), 32'd0);
    check_eq("dly_lat", 32'(lat), 32'd8);

    do_req(0, 1, 1, 8'h0A, 32'h5A5A_5A5A, 32'h0, 0);
    check_eq("rw_as_write_hit", 32'(cap_hit), 32'd1);
    check_eq("rw_as_write_nrd", 32'(n_rd), 32'd0);
    do_req(0, 1, 0, 8'h0A, 32'h0, 32'h0, 0);
    check_eq("rw_line_data", cap_data, 32'h5A5A_5A5A);

    // ---------------- write-through instance ----------------
    do_req(1, 1, 0, 8'h0A, 32'h0, 32'hFFFF_FFFF, 0);
    check_eq("wt_rd_miss_hit", 32'(cap_hit), 32'd0);
    check_eq("wt_rd_miss_data", cap_data, 32'hFFFF_FFFF);

    do_req(1, 0, 1, 8'h0A, 32'h1111_1111, 32'h0, 0);
    check_eq("wt_wr_hit_hit", 32'(cap_hit), 32'd1);
    check_eq("wt_wr_hit_nwr", 32'(n_wr), 32'd1);
    check_eq("wt_wr_hit_addr", 32'(wr_addr), 32'h08);
    check_eq("wt_wr_hit_wdata", wr_data, 32'h1111_1111);
    check_eq("wt_wr_hit_nrd", 32'(n_rd), 32'd0);
    check_eq("wt_wr_hit_lat", 32'(lat), 32'd3);

    do_req(1, 1, 0, 8'h0A, 32'h0, 32'h0, 0);
    check_eq("wt_line_updated", cap_data, 32'h1111_1111);

    do_req(1, 0, 1, 8'h4A, 32'h2222_2222, 32'h0, 0);
    check_eq("wt_wr_miss_hit", 32'(cap_hit), 32'd0);
    check_eq("wt_wr_miss_addr", 32'(wr_addr), 32'h48);
    check_eq("wt_wr_miss_nrd", 32'(n_rd), 32'd0);

    do_req(1, 1, 0, 8'h4A, 32'h0, 32'h3333_3333, 0);
    check_eq("wt_no_alloc_hit", 32'(cap_hit), 32'd0);
    check_eq("wt_no_alloc_addr", 32'(rd_addr), 32'h48);
    check_eq("wt_no_alloc_data", cap_data, 32'h3333_3333);

    do_req(1, 1, 0, 8'h0A, 32'h0, 32'h0, 0);
    check_eq("wt_0a_still_hit", 32'(cap_hit), 32'd1);
    check_eq("wt_never_dirty", 32'(n_wr), 32'd0);

    // ---------------- reset during FILL ----------------
    @(negedge clk);
    l1_addr[1] = 8'h8A; l1_rd[1] = 1'b1; mem_blk[1] = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 l1_rd[1] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (m_rd[1]) seen = 1'b1;
    end
    check_eq("rst_fill_entered", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_mem_read", 32'(m_rd[1]), 32'd0);
    check_eq("rst_mid_ready", 32'(l1_ready[1]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    resp_after_rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (l1_valid[1] || l1_valid[0]) resp_after_rst = 1'b1;
    end
    check_eq("rst_mid_no_resp", 32'(resp_after_rst), 32'd0);

    do_req(1, 1, 0, 8'h0A, 32'h0, 32'h7777_7777, 0);
    check_eq("wt_post_rst_miss", 32'(cap_hit), 32'd0);
    check_eq("wt_post_rst_nrd", 32'(n_rd), 32'd1);
    do_req(0, 1, 0, 8'h0A, 32'h0, 32'h6666_6666, 0);
    check_eq("wb_post_rst_miss", 32'(cap_hit), 32'd0);
    check_eq("wb_post_rst_data", cap_data, 32'h6666_6666);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
